// File: rtl/evict_wb_buffer.sv
// Eviction writeback buffer: an in-order FIFO of dirty evicted cache lines
// waiting to be written to memory, with a combinational address lookup so a
// refill can pick up data that has not reached memory yet.
module evict_wb_buffer #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic                    push_dirty_i,
  input  logic [ADDR_WIDTH-1:0]   push_addr_i,
  input  logic [LINE_WIDTH-1:0]   push_line_i,
  output logic                    mem_wr_valid_o,
  input  logic                    mem_wr_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr_o,
  output logic [LINE_WIDTH-1:0]   mem_wr_data_o,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
  output logic                    lookup_hit_o,
  output logic [LINE_WIDTH-1:0]   lookup_line_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;
  localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [LINE_WIDTH-1:0] r_line_mem [DEPTH];

  logic                  w_push_fire;
  logic                  w_store;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_push_aligned;
  logic [ADDR_WIDTH-1:0] w_lookup_aligned;
  logic                  w_lookup_hit;
  logic [LINE_WIDTH-1:0] w_lookup_line;

  // Ready depends only on the registered count, so there is no path from
  // mem_wr_ready_i to push_ready_o.
  assign push_ready_o     = (r_count != FULL_CNT);
  assign mem_wr_valid_o   = (r_count != '0);
  assign w_push_fire      = push_valid_i && push_ready_o;
  assign w_store          = w_push_fire && push_dirty_i;
  assign w_pop            = mem_wr_valid_o && mem_wr_ready_i;
  assign w_push_aligned   = push_addr_i & ALIGN_MASK;
  assign w_lookup_aligned = lookup_addr_i & ALIGN_MASK;

  // Storage is not reset, so gate the head entry to keep the outputs at zero
  // whenever the buffer is empty.
  assign mem_wr_addr_o    = mem_wr_valid_o ? r_addr_mem[r_head] : '0;
  assign mem_wr_data_o    = mem_wr_valid_o ? r_line_mem[r_head] : '0;
  assign lookup_hit_o     = w_lookup_hit;
  assign lookup_line_o    = w_lookup_line;
  assign count_o          = r_count;

  // Pointer and occupancy tracking; clean pushes are acknowledged but dropped.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_tail <= r_tail + 1'b1;
      if (w_pop)   r_head <= r_head + 1'b1;
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write at the tail.
  always_ff @(posedge clk_i) begin
    // NOTE: the entry arrays have no reset; unoccupied entries are never
    // observed because every read is qualified by the occupancy count.
    if (w_store && !rst_i) begin
      r_addr_mem[r_tail] <= w_push_aligned;
      r_line_mem[r_tail] <= push_line_i;
    end
  end

  // Lookup scans oldest to youngest so the youngest match overrides.
  always_comb begin
    // NOTE: defaults are assigned first so no path through the loop leaves
    // an output unassigned, which would infer a latch.
    w_lookup_hit  = 1'b0;
    w_lookup_line = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) &&
          (r_addr_mem[r_head + PTR_W'(k)] == w_lookup_aligned)) begin
        w_lookup_hit  = 1'b1;
        w_lookup_line = r_line_mem[r_head + PTR_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_evict_wb_buffer.sv
// Directed bench for evict_wb_buffer: a vector table for single-cycle
// behaviour plus hand-written sequences for fill, wrap and reset cases.
module tb_evict_wb_buffer;

  localparam int LW = 512;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          push_valid_i;
  logic          push_ready_o;
  logic          push_dirty_i;
  logic [AW-1:0] push_addr_i;
  logic [LW-1:0] push_line_i;
  logic          mem_wr_valid_o;
  logic          mem_wr_ready_i;
  logic [AW-1:0] mem_wr_addr_o;
  logic [LW-1:0] mem_wr_data_o;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_hit_o;
  logic [LW-1:0] lookup_line_o;
  logic [2:0]    count_o;

  int n_tests = 0;
  int n_fail  = 0;

  evict_wb_buffer #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_dirty_i(push_dirty_i), .push_addr_i(push_addr_i),
    .push_line_i(push_line_i),
    .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
    .lookup_line_o(lookup_line_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Line data is a byte tag replicated across the line; tag 0 means all-zero.
  function automatic logic [LW-1:0] pat(input logic [7:0] t);
    return {(LW/8){t}};
  endfunction

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          pv, pd;
    logic [AW-1:0] pa;
    logic [7:0]    pt;
    logic          mr;
    logic [AW-1:0] la;
    logic [2:0]    e_cnt;
    logic          e_pr, e_mv;
    logic [AW-1:0] e_ma;
    logic [7:0]    e_md;
    logic          e_hit;
    logic [7:0]    e_ln;
  } vec_t;

  vec_t vecs[15];

  task automatic idle_inputs();
    push_valid_i = 1'b0; push_dirty_i = 1'b0; push_addr_i = '0;
    push_line_i = '0; mem_wr_ready_i = 1'b0; lookup_addr_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] t, input logic rdy);
    push_valid_i = 1'b1; push_dirty_i = 1'b1; push_addr_i = a;
    push_line_i = pat(t); mem_wr_ready_i = rdy;
    @(posedge clk_i); #1;
    push_valid_i = 1'b0;
  endtask

  logic [7:0]    q_tag[$];
  logic [AW-1:0] q_addr[$];

  initial begin
    // Each row: inputs applied, outputs checked before the edge, then clocked.
    //            pv    pd    pa           pt     mr    la            cnt pr    mv    ma           md     hit   ln
    vecs[0]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h0,       0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h1234,    8'hA1, 1'b1, 32'h1234,    0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1, 32'h1200,    1, 1'b1, 1'b1, 32'h1200,    8'hA1, 1'b1, 8'hA1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h1200,    0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 32'h2000,    8'hB2, 1'b0, 32'h2000,    0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h2000,    0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1, 32'h0,       0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h0,       0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 32'h40,      8'hB0, 1'b0, 32'h40,      0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 32'h7F,      8'hC0, 1'b0, 32'h7F,      1, 1'b1, 1'b1, 32'h40,      8'hB0, 1'b1, 8'hB0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h7F,      2, 1'b1, 1'b1, 32'h40,      8'hB0, 1'b1, 8'hC0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h80,      2, 1'b1, 1'b1, 32'h40,      8'hB0, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1, 32'h40,      2, 1'b1, 1'b1, 32'h40,      8'hB0, 1'b1, 8'hC0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b1, 32'h40,      1, 1'b1, 1'b1, 32'h40,      8'hC0, 1'b1, 8'hC0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,       8'h00, 1'b0, 32'h40,      0, 1'b1, 1'b0, 32'h0,       8'h00, 1'b0, 8'h00};

    do_reset();

    for (int i = 0; i < 15; i++) begin
      push_valid_i = vecs[i].pv; push_dirty_i = vecs[i].pd;
      push_addr_i = vecs[i].pa; push_line_i = pat(vecs[i].pt);
      mem_wr_ready_i = vecs[i].mr; lookup_addr_i = vecs[i].la;
      @(negedge clk_i);
      check($sformatf("v%0d count", i),  LW'(count_o),        LW'(vecs[i].e_cnt));
      check($sformatf("v%0d pready", i), LW'(push_ready_o),   LW'(vecs[i].e_pr));
      check($sformatf("v%0d mvalid", i), LW'(mem_wr_valid_o), LW'(vecs[i].e_mv));
      check($sformatf("v%0d maddr", i),  LW'(mem_wr_addr_o),  LW'(vecs[i].e_ma));
      check($sformatf("v%0d mdata", i),  mem_wr_data_o,       pat(vecs[i].e_md));
      check($sformatf("v%0d hit", i),    LW'(lookup_hit_o),   LW'(vecs[i].e_hit));
      check($sformatf("v%0d line", i),   lookup_line_o,       pat(vecs[i].e_ln));
      @(posedge clk_i); #1;
    end
    idle_inputs();

    // Fill to DEPTH with memory stalled, then drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h100 * (i + 1), 8'h10 + 8'(i), 1'b0);
    @(negedge clk_i);
    check("full count",  LW'(count_o),      LW'(3'd4));
    check("full pready", LW'(push_ready_o), LW'(1'b0));
    push(32'h900, 8'h99, 1'b0);
    @(negedge clk_i);
    check("full ignore count", LW'(count_o),       LW'(3'd4));
    check("full ignore head",  LW'(mem_wr_addr_o), LW'(32'h100));
    @(posedge clk_i); #1;
    mem_wr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check($sformatf("drain%0d valid", i), LW'(mem_wr_valid_o), LW'(1'b1));
      check($sformatf("drain%0d addr", i),  LW'(mem_wr_addr_o),  LW'(32'h100 * (i + 1)));
      check($sformatf("drain%0d data", i),  mem_wr_data_o,       pat(8'h10 + 8'(i)));
      @(posedge clk_i); #1;
      if (i == 0) check("drain pready", LW'(push_ready_o), LW'(1'b1));
    end
    mem_wr_ready_i = 1'b0;
    @(negedge clk_i);
    check("drained count", LW'(count_o),        LW'(3'd0));
    check("drained valid", LW'(mem_wr_valid_o), LW'(1'b0));
    @(posedge clk_i); #1;

    // Steady push+pop at count 2 for 10 cycles across pointer wrap.
    do_reset();
    push(32'h500, 8'h20, 1'b0); q_addr.push_back(32'h500); q_tag.push_back(8'h20);
    push(32'h540, 8'h21, 1'b0); q_addr.push_back(32'h540); q_tag.push_back(8'h21);
    for (int j = 0; j < 10; j++) begin
      push_valid_i = 1'b1; push_dirty_i = 1'b1; mem_wr_ready_i = 1'b1;
      push_addr_i = 32'h1000 + 32'(j) * 32'h40; push_line_i = pat(8'h30 + 8'(j));
      @(negedge clk_i);
      check($sformatf("wrap%0d count", j), LW'(count_o),       LW'(3'd2));
      check($sformatf("wrap%0d addr", j),  LW'(mem_wr_addr_o), LW'(q_addr[0]));
      check($sformatf("wrap%0d data", j),  mem_wr_data_o,      pat(q_tag[0]));
      @(posedge clk_i); #1;
      void'(q_addr.pop_front()); void'(q_tag.pop_front());
      q_addr.push_back(32'h1000 + 32'(j) * 32'h40); q_tag.push_back(8'h30 + 8'(j));
    end
    idle_inputs();

    // Reset with three pending entries and a push and pop on the same edge.
    push(32'h2000, 8'h77, 1'b0);
    @(negedge clk_i);
    check("pre-reset count", LW'(count_o), LW'(3'd3));
    @(posedge clk_i); #1;
    push_valid_i = 1'b1; push_dirty_i = 1'b1; push_addr_i = 32'h3000;
    push_line_i = pat(8'h88); mem_wr_ready_i = 1'b1; rst_i = 1'b1;
    @(posedge clk_i); #1;
    idle_inputs(); rst_i = 1'b0; lookup_addr_i = 32'h2000;
    @(negedge clk_i);
    check("rst count",  LW'(count_o),        LW'(3'd0));
    check("rst valid",  LW'(mem_wr_valid_o), LW'(1'b0));
    check("rst pready", LW'(push_ready_o),   LW'(1'b1));
    check("rst addr",   LW'(mem_wr_addr_o),  LW'(32'h0));
    check("rst data",   mem_wr_data_o,       pat(8'h00));
    check("rst hit",    LW'(lookup_hit_o),   LW'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
